// File: rtl/sata_link_supervisor_pkg.sv
// -----------------------------------------------------------------------------
// sata_link_supervisor_pkg
//   Shared definitions for the SATA link supervisor: state encodings, default
//   timing values and small saturating/shift helpers used by the top level.
// -----------------------------------------------------------------------------
package sata_link_supervisor_pkg;

  // Supervisor state encodings (also exported on sup_state for debug).
  typedef enum logic [2:0] {
    SUP_IDLE    = 3'd0,
    SUP_HOLD    = 3'd1,
    SUP_TRAIN   = 3'd2,
    SUP_LINKED  = 3'd3,
    SUP_BACKOFF = 3'd4,
    SUP_FAILED  = 3'd5
  } sup_state_t;

  // Default timing values.
  localparam logic [31:0] SUP_HOLD_CYCLES   = 32'd64;
  localparam logic [31:0] SUP_TRAIN_TIMEOUT = 32'd2000000;
  localparam logic [31:0] SUP_BACKOFF_BASE  = 32'd1024;
  localparam logic [3:0]  SUP_MAX_RETRIES   = 4'd8;
  localparam logic [7:0]  SUP_ERR_LIMIT     = 8'd16;

  // Exponential backoff: base shifted by the retry count, shift capped at 7.
  // Bits shifted past bit 31 are intentionally lost.
  function automatic logic [31:0] backoff_cycles(input logic [31:0] base,
                                                 input logic [3:0]  retries);
    logic [2:0] sh;
    sh = (retries > 4'd7) ? 3'd7 : retries[2:0];
    return base << sh;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sata_sup_timer.sv
// -----------------------------------------------------------------------------
// sata_sup_timer
//   Loadable 32-bit down-counter that stops at zero.
//   Ports:
//     clk       : clock
//     rst       : asynchronous active-low reset (count -> 0)
//     load      : load load_val this cycle (takes priority over counting)
//     load_val  : value to load
//     zero      : count equals 0 in the current cycle
// -----------------------------------------------------------------------------
module sata_sup_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        zero
);

  logic [31:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= 32'd0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != 32'd0) begin
      count_reg <= count_reg - 32'd1;
    end
  end

  // Combinational so the FSM sees "reached 0" in the same cycle it happens.
  assign zero = (count_reg == 32'd0);

endmodule

// File: rtl/sata_link_supervisor.sv
// -----------------------------------------------------------------------------
// sata_link_supervisor
//   Supervisory sequencer above the OOB controller. Holds the OOB controller in
//   reset until the platform is stable, gives it a bounded training window,
//   retries with exponential backoff up to a retry limit, and restarts training
//   when an established link drops or sees a burst of PHY errors.
//   Ports:
//     clk                : clock (same domain as the OOB controller)
//     rst                : asynchronous active-low reset
//     platform_ready     : PLL/DCM locked
//     user_reset_req     : one-cycle request for a full link re-init
//     oob_linkup         : linkup from the OOB controller
//     phy_error          : PHY decode/disparity error
//     oob_rst            : active-high reset to the OOB controller
//     oob_platform_ready : platform_ready to the OOB controller
//     link_up            : link usable
//     link_failed        : retries exhausted
//     link_lost          : one-cycle pulse when an established link drops
//     retry_count        : failed attempts since last success / user reset
//     sup_state          : state encoding, for debug
//   All outputs are registered from the state register, so each output
//   reflects a state the cycle after that state is entered.
// -----------------------------------------------------------------------------
module sata_link_supervisor
  import sata_link_supervisor_pkg::*;
#(
  parameter logic [31:0] HOLD_CYCLES   = SUP_HOLD_CYCLES,
  parameter logic [31:0] TRAIN_TIMEOUT = SUP_TRAIN_TIMEOUT,
  parameter logic [31:0] BACKOFF_BASE  = SUP_BACKOFF_BASE,
  parameter logic [3:0]  MAX_RETRIES   = SUP_MAX_RETRIES,
  parameter logic [7:0]  ERR_LIMIT     = SUP_ERR_LIMIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       platform_ready,
  input  logic       user_reset_req,
  input  logic       oob_linkup,
  input  logic       phy_error,
  output logic       oob_rst,
  output logic       oob_platform_ready,
  output logic       link_up,
  output logic       link_failed,
  output logic       link_lost,
  output logic [3:0] retry_count,
  output logic [2:0] sup_state
);

  sup_state_t  state_reg, state_next;
  logic [3:0]  retry_reg, retry_next;
  logic [7:0]  err_reg, err_next;
  logic        lost_reg, lost_next;
  logic        timer_load;
  logic [31:0] timer_val;
  logic        timer_zero;

  sata_sup_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  // Next-state decisions. The timer load must happen in the same cycle as the
  // transition, so it is decided here alongside the state.
  always_comb begin
    state_next = state_reg;
    retry_next = retry_reg;
    err_next   = err_reg;
    lost_next  = 1'b0;
    timer_load = 1'b0;
    timer_val  = 32'd0;

    if (!platform_ready) begin
      state_next = SUP_IDLE;
      retry_next = 4'd0;
    end else if (user_reset_req && (state_reg != SUP_IDLE)) begin
      retry_next = 4'd0;
      timer_load = 1'b1;
      timer_val  = HOLD_CYCLES;
      state_next = SUP_HOLD;
    end else begin
      case (state_reg)
        SUP_IDLE: begin
          timer_load = 1'b1;
          timer_val  = HOLD_CYCLES;
          state_next = SUP_HOLD;
        end
        SUP_HOLD: begin
          if (timer_zero) begin
            timer_load = 1'b1;
            timer_val  = TRAIN_TIMEOUT;
            state_next = SUP_TRAIN;
          end
        end
        SUP_TRAIN: begin
          // Linkup wins over a coincident timeout.
          if (oob_linkup) begin
            retry_next = 4'd0;
            err_next   = 8'd0;
            state_next = SUP_LINKED;
          end else if (timer_zero) begin
            retry_next = sat_inc4(retry_reg);
            if (retry_reg == (MAX_RETRIES - 4'd1)) begin
              state_next = SUP_FAILED;
            end else begin
              // Backoff uses the count before this failure is added.
              timer_load = 1'b1;
              timer_val  = backoff_cycles(BACKOFF_BASE, retry_reg);
              state_next = SUP_BACKOFF;
            end
          end
        end
        SUP_LINKED: begin
          // Counts consecutive error cycles only; any clean cycle clears it.
          err_next = phy_error ? sat_inc8(err_reg) : 8'd0;
          if (!oob_linkup || (err_reg >= ERR_LIMIT)) begin
            lost_next  = 1'b1;
            timer_load = 1'b1;
            timer_val  = HOLD_CYCLES;
            state_next = SUP_HOLD;
          end
        end
        SUP_BACKOFF: begin
          if (timer_zero) begin
            timer_load = 1'b1;
            timer_val  = HOLD_CYCLES;
            state_next = SUP_HOLD;
          end
        end
        SUP_FAILED: begin
          // Left only through the global platform/user-reset paths above.
        end
        default: begin
          state_next = SUP_IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg          <= SUP_IDLE;
      retry_reg          <= 4'd0;
      err_reg            <= 8'd0;
      lost_reg           <= 1'b0;
      oob_rst            <= 1'b1;
      oob_platform_ready <= 1'b0;
      link_up            <= 1'b0;
      link_failed        <= 1'b0;
      link_lost          <= 1'b0;
      retry_count        <= 4'd0;
      sup_state          <= SUP_IDLE;
    end else begin
      state_reg <= state_next;
      retry_reg <= retry_next;
      err_reg   <= err_next;
      lost_reg  <= lost_next;

      // The OOB controller runs only while training or linked.
      oob_rst            <= !((state_reg == SUP_TRAIN) || (state_reg == SUP_LINKED));
      oob_platform_ready <= (state_reg != SUP_IDLE) && (state_reg <= SUP_FAILED);
      link_up            <= (state_reg == SUP_LINKED);
      link_failed        <= (state_reg == SUP_FAILED);
      // lost_reg is set on the LINKED->HOLD edge, so link_lost rises in the
      // same cycle link_up falls.
      link_lost          <= lost_reg;
      retry_count        <= retry_reg;
      sup_state          <= state_reg;
    end
  end

endmodule

// File: tb/tb_sata_link_supervisor.sv
// -----------------------------------------------------------------------------
// tb_sata_link_supervisor
//   Directed + randomized stimulus against a phase/elapsed-time reference model
//   of the supervisor, compared on every clock and at scenario checkpoints.
// -----------------------------------------------------------------------------
module tb_sata_link_supervisor;

  localparam int HOLD  = 4;
  localparam int TRAIN = 150;
  localparam int BASE  = 8;
  localparam int MAXR  = 3;
  localparam int LIM   = 16;

  // Phase numbers equal the visible sup_state values.
  localparam int P_IDLE = 0, P_HOLD = 1, P_TRAIN = 2, P_LINKED = 3,
                 P_BACKOFF = 4, P_FAILED = 5;

  logic       clk;
  logic       rst;
  logic       platform_ready;
  logic       user_reset_req;
  logic       oob_linkup;
  logic       phy_error;
  logic       oob_rst;
  logic       oob_platform_ready;
  logic       link_up;
  logic       link_failed;
  logic       link_lost;
  logic [3:0] retry_count;
  logic [2:0] sup_state;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state.
  int m_phase, m_elapsed, m_dur, m_retries, m_errs;
  bit m_lost;
  int e_state, e_oob_rst, e_opr, e_up, e_failed, e_lost, e_retry;

  sata_link_supervisor #(
    .HOLD_CYCLES   (32'd4),
    .TRAIN_TIMEOUT (32'd150),
    .BACKOFF_BASE  (32'd8),
    .MAX_RETRIES   (4'd3),
    .ERR_LIMIT     (8'd16)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .platform_ready     (platform_ready),
    .user_reset_req     (user_reset_req),
    .oob_linkup         (oob_linkup),
    .phy_error          (phy_error),
    .oob_rst            (oob_rst),
    .oob_platform_ready (oob_platform_ready),
    .link_up            (link_up),
    .link_failed        (link_failed),
    .link_lost          (link_lost),
    .retry_count        (retry_count),
    .sup_state          (sup_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at %0t: observed %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_elapsed = 0; m_dur = 0; m_retries = 0; m_errs = 0; m_lost = 0;
    e_state = 0; e_oob_rst = 1; e_opr = 0; e_up = 0; e_failed = 0; e_lost = 0; e_retry = 0;
  endtask

  // Advance the model across one rising edge using the inputs present there.
  task automatic model_step();
    int  nxt;
    bit  enter;
    bit  new_lost;
    bit  loss;
    int  old;
    if (!rst) begin
      model_reset();
      return;
    end
    // Outputs seen after this edge describe the phase held before it.
    e_state   = m_phase;
    e_oob_rst = (m_phase == P_TRAIN || m_phase == P_LINKED) ? 0 : 1;
    e_opr     = (m_phase != P_IDLE) ? 1 : 0;
    e_up      = (m_phase == P_LINKED) ? 1 : 0;
    e_failed  = (m_phase == P_FAILED) ? 1 : 0;
    e_lost    = m_lost ? 1 : 0;
    e_retry   = m_retries;

    nxt = m_phase; enter = 0; new_lost = 0;
    if (!platform_ready) begin
      if (m_phase != P_IDLE) begin nxt = P_IDLE; enter = 1; end
      m_retries = 0;
    end else if (user_reset_req && m_phase != P_IDLE) begin
      m_retries = 0; nxt = P_HOLD; enter = 1;
    end else begin
      case (m_phase)
        P_IDLE: begin nxt = P_HOLD; enter = 1; end
        P_HOLD: if (m_elapsed == HOLD + 1) begin nxt = P_TRAIN; enter = 1; end
        P_TRAIN: begin
          if (oob_linkup) begin
            m_retries = 0; m_errs = 0; nxt = P_LINKED; enter = 1;
          end else if (m_elapsed == TRAIN + 1) begin
            old = m_retries;
            m_retries = (old >= 15) ? 15 : old + 1;
            if (old == MAXR - 1) begin
              nxt = P_FAILED; enter = 1;
            end else begin
              m_dur = (BASE << ((old > 7) ? 7 : old)) + 1;
              nxt = P_BACKOFF; enter = 1;
            end
          end
        end
        P_LINKED: begin
          loss = !oob_linkup || (m_errs >= LIM);
          m_errs = phy_error ? ((m_errs >= 255) ? 255 : m_errs + 1) : 0;
          if (loss) begin new_lost = 1; nxt = P_HOLD; enter = 1; end
        end
        P_BACKOFF: if (m_elapsed == m_dur) begin nxt = P_HOLD; enter = 1; end
        default: ;
      endcase
    end
    m_lost    = new_lost;
    m_phase   = nxt;
    m_elapsed = enter ? 1 : m_elapsed + 1;
  endtask

  task automatic check_outputs();
    chk("sup_state",          {29'd0, sup_state},          e_state);
    chk("oob_rst",            {31'd0, oob_rst},            e_oob_rst);
    chk("oob_platform_ready", {31'd0, oob_platform_ready}, e_opr);
    chk("link_up",            {31'd0, link_up},            e_up);
    chk("link_failed",        {31'd0, link_failed},        e_failed);
    chk("link_lost",          {31'd0, link_lost},          e_lost);
    chk("retry_count",        {28'd0, retry_count},        e_retry);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic wait_state(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (sup_state !== 3'(target) && k < budget) begin
      tick();
      k++;
    end
    chk(tag, {29'd0, sup_state}, target);
  endtask

  initial begin
    int runs[$];
    int run;
    int lost_cnt;
    int st_at_lost;
    int up_at_lost;
    int hold_run;
    int r0, r1;

    rst = 1'b1; platform_ready = 1'b0; user_reset_req = 1'b0;
    oob_linkup = 1'b0; phy_error = 1'b0;

    // 1: reset values, before any clock edge.
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    tick(); tick();
    @(negedge clk) rst = 1'b1;
    tick(); tick();
    $display("step reset: done at %0t", $time);

    // 2: bring-up, linkup about 100 cycles into TRAIN.
    platform_ready = 1'b1;
    wait_state(P_TRAIN, 40, "wait_train_first");
    repeat (99) tick();
    oob_linkup = 1'b1;
    tick();
    chk("link_up_after_1", {31'd0, link_up}, 0);
    tick();
    chk("link_up_after_2", {31'd0, link_up}, 1);
    chk("retry_after_link", {28'd0, retry_count}, 0);
    $display("step linkup: link_up=%0b at %0t", link_up, $time);

    // 3: error bursts of 15 (survives) and 16 (link lost).
    tick();
    phy_error = 1'b1;
    repeat (15) tick();
    phy_error = 1'b0;
    repeat (3) tick();
    chk("err15_stays_linked", {29'd0, sup_state}, P_LINKED);
    phy_error = 1'b1;
    lost_cnt = 0; st_at_lost = -1; up_at_lost = -1;
    for (int i = 0; i < 30; i++) begin
      if (i == 16) phy_error = 1'b0;
      tick();
      if (link_lost === 1'b1) begin
        lost_cnt++;
        st_at_lost = sup_state;
        up_at_lost = link_up;
      end
    end
    chk("err16_lost_pulses", lost_cnt, 1);
    chk("err16_state_hold", st_at_lost, P_HOLD);
    chk("err16_link_up_low", up_at_lost, 0);
    $display("step error burst: link_lost pulses=%0d", lost_cnt);

    // 4: random errors and linkup drops while linked.
    wait_state(P_LINKED, 40, "wait_relink");
    for (int i = 0; i < 400; i++) begin
      phy_error  = ($urandom_range(0, 99) < 90);
      oob_linkup = ($urandom_range(0, 99) != 0);
      tick();
    end
    phy_error = 1'b0;
    $display("step random linked: done at %0t", $time);

    // 5: training never succeeds -> backoff 9 and 17 cycles, then FAILED.
    oob_linkup = 1'b0;
    user_reset_req = 1'b1;
    tick();
    user_reset_req = 1'b0;
    run = 0;
    for (int k = 0; k < 2000 && sup_state !== 3'(P_FAILED); k++) begin
      tick();
      if (sup_state === 3'(P_BACKOFF)) run++;
      else if (run > 0) begin runs.push_back(run); run = 0; end
    end
    r0 = (runs.size() > 0) ? runs[0] : -1;
    r1 = (runs.size() > 1) ? runs[1] : -1;
    chk("backoff_count", runs.size(), 2);
    chk("backoff_len_0", r0, 9);
    chk("backoff_len_1", r1, 17);
    chk("failed_flag", {31'd0, link_failed}, 1);
    chk("failed_retry", {28'd0, retry_count}, 3);
    chk("failed_oob_rst", {31'd0, oob_rst}, 1);
    $display("step failure: backoffs %0d/%0d retry=%0d", r0, r1, retry_count);

    // 6: user reset from FAILED.
    tick();
    user_reset_req = 1'b1;
    tick();
    user_reset_req = 1'b0;
    tick();
    chk("urr_state_hold", {29'd0, sup_state}, P_HOLD);
    chk("urr_retry_clear", {28'd0, retry_count}, 0);
    chk("urr_failed_clear", {31'd0, link_failed}, 0);
    wait_state(P_TRAIN, 20, "urr_to_train");
    $display("step user reset: state=%0d", sup_state);

    // 7: user reset coinciding with platform_ready loss -> IDLE.
    wait_state(P_FAILED, 2000, "refail");
    user_reset_req = 1'b1;
    platform_ready = 1'b0;
    tick();
    user_reset_req = 1'b0;
    tick();
    chk("urr_prlow_idle", {29'd0, sup_state}, P_IDLE);
    chk("urr_prlow_retry", {28'd0, retry_count}, 0);
    platform_ready = 1'b1;
    $display("step urr+platform loss: state=%0d", sup_state);

    // 8: asynchronous reset mid-BACKOFF, then full restart.
    wait_state(P_BACKOFF, 600, "wait_backoff");
    repeat (3) tick();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("async_rst_oob_rst", {31'd0, oob_rst}, 1);
    tick(); tick();
    @(negedge clk) rst = 1'b1;
    wait_state(P_HOLD, 20, "restart_hold");
    hold_run = 0;
    while (sup_state === 3'(P_HOLD) && hold_run < 50) begin
      hold_run++;
      tick();
    end
    chk("restart_hold_len", hold_run, HOLD + 1);
    $display("step async reset: hold length=%0d", hold_run);

    // 9: random soak of all inputs.
    for (int i = 0; i < 2500; i++) begin
      platform_ready = ($urandom_range(0, 299) != 0);
      user_reset_req = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) oob_linkup = ~oob_linkup;
      phy_error = ($urandom_range(0, 99) < 30);
      tick();
    end
    user_reset_req = 1'b0;
    $display("step random soak: done at %0t", $time);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sata_link_supervisor.md
# sata_link_supervisor

Supervisory sequencer above `oob_controller` in the SATA PHY layer. It holds the OOB controller in reset until the platform is stable, then releases it and gives it a bounded training window. On training failure it retries with exponential backoff up to a retry limit. While the link is up it watches for link loss and PHY error bursts and restarts training when either occurs.

## Interface
Parameters:
- `HOLD_CYCLES`, 32'd64: cycles `oob_rst` is held before each training attempt.
- `TRAIN_TIMEOUT`, 32'd2000000: cycles allowed for `oob_linkup` to assert.
- `BACKOFF_BASE`, 32'd1024: base backoff in cycles, shifted left by the retry count.
- `MAX_RETRIES`, 4'd8: failed attempts before entering FAILED.
- `ERR_LIMIT`, 8'd16: consecutive `phy_error` cycles that declare the link lost.

Ports:
- `clk` in 1: single clock (same domain as `oob_controller`).
- `rst` in 1: asynchronous, active-low reset.
- `platform_ready` in 1: PLL/DCM locked.
- `user_reset_req` in 1: one-cycle request for a full link re-init.
- `oob_linkup` in 1: `linkup` from the OOB controller.
- `phy_error` in 1: PHY decode/disparity error.
- `oob_rst` out 1: active-high synchronous reset to the OOB controller.
- `oob_platform_ready` out 1: drives the OOB controller's `platform_ready`.
- `link_up` out 1: link usable.
- `link_failed` out 1: retries exhausted.
- `link_lost` out 1: one-cycle pulse when an established link drops.
- `retry_count` out 4: failed attempts since the last success or user reset.
- `sup_state` out 3: state encoding, for debug.

## Operation
- States: IDLE=0, HOLD=1, TRAIN=2, LINKED=3, BACKOFF=4, FAILED=5. Any other encoding goes to IDLE.
- IDLE: `oob_rst`=1, `oob_platform_ready`=0. When `platform_ready`=1: load the timer with `HOLD_CYCLES`, go to HOLD.
- HOLD: `oob_rst`=1. When the timer reaches 0: load the timer with `TRAIN_TIMEOUT`, go to TRAIN.
- TRAIN: `oob_rst`=0, `oob_platform_ready`=1.
  - If `oob_linkup`: clear `retry_count` and the error counter, go to LINKED.
  - Else if the timer reaches 0 and `retry_count`==`MAX_RETRIES`-1: `retry_count`++, go to FAILED.
  - Else if the timer reaches 0: `retry_count`++, load the timer with `BACKOFF_BASE << min(retry_count,7)` (32-bit, bits above 31 dropped), go to BACKOFF.
  - If `oob_linkup` and timeout occur in the same cycle, linkup wins.
- LINKED: `link_up`=1, `oob_rst`=0.
  - Error counter: 8-bit; increments on `phy_error`, clears on any cycle without `phy_error`, saturates at 255.
  - Link loss: `!oob_linkup`, or the counter reaching `ERR_LIMIT`.
  - On link loss: pulse `link_lost`, load the timer with `HOLD_CYCLES`, go to HOLD. `retry_count` is not changed.
- BACKOFF: `oob_rst`=1. When the timer reaches 0: load `HOLD_CYCLES`, go to HOLD.
- FAILED: `link_failed`=1, `oob_rst`=1. Exits only via `user_reset_req` or loss of `platform_ready`.
- Global priority, evaluated every cycle:
  1. `platform_ready`=0: go to IDLE and clear `retry_count`.
  2. `user_reset_req`=1 in any state except IDLE: clear `retry_count`, load `HOLD_CYCLES`, go to HOLD.
  3. Per-state logic above.
- `retry_count` saturates at 15.
- Timer: 32-bit down-counter that stops at 0. Reaching 0 means the counter equals 0 in the current cycle.

## Timing
- All outputs are registered. An output reflects a state in the cycle after that state is entered.
- Reset values:
  - `sup_state`=IDLE, `oob_rst`=1, `oob_platform_ready`=0.
  - `link_up`=0, `link_failed`=0, `link_lost`=0.
  - `retry_count`=0, timer=0, error counter=0.
- Durations:
  - HOLD lasts `HOLD_CYCLES`+1 cycles.
  - TRAIN times out `TRAIN_TIMEOUT`+1 cycles after entry.
  - `oob_linkup` to `link_up`: 2 cycles (state update, then output register).
- `link_lost` is high for exactly one cycle. `link_up` falls in the same cycle that `link_lost` rises.
- Asynchronous assertion of `rst` forces the reset values immediately, mid-timer included. Deassertion is synchronized by the integrator.

## Structure
- Add to `sata_defines.v`: supervisor state encodings (`SUP_IDLE` .. `SUP_FAILED`) and default `SUP_TRAIN_TIMEOUT`/`SUP_BACKOFF_BASE` values.
- Sub-module `sata_sup_timer`: loadable 32-bit down-counter that stops at 0, with `load`, `load_val` and `zero` ports.
- The FSM, retry counter and error counter live in the top module.

## Test plan
- `platform_ready` rises, `oob_linkup` rises 100 cycles into TRAIN (`HOLD_CYCLES`=4) → `oob_rst` low for 100 cycles, `link_up`=1 two cycles after `oob_linkup`, `retry_count`=0.
- `oob_linkup` never asserts, `MAX_RETRIES`=3, `BACKOFF_BASE`=8 → backoffs of 9 and 17 cycles, `retry_count` 1→2→3, `link_failed`=1, `oob_rst`=1.
- In LINKED, `phy_error` held 16 cycles (`ERR_LIMIT`=16) → one-cycle `link_lost`, state HOLD. `phy_error` held 15 cycles then one clean cycle → stays LINKED.
- `user_reset_req` pulse in FAILED → `retry_count`=0, `link_failed`=0, HOLD then TRAIN. Same pulse in the same cycle as `platform_ready`=0 → IDLE.
- `rst` asserted mid-BACKOFF with timer=500 → all outputs at reset values immediately. After release with `platform_ready`=1 → full HOLD sequence restarts.
